freq_sort_n: RTL and testbench
==============================

# freq_sort_n

Parametrised, sequential frequency sorter for the Huffman encoder. It accepts N packed W-bit symbol frequencies and sorts them with an odd-even transposition network, one compare-swap phase per clock. Each entry carries a tag holding its original symbol index, so the tree builder downstream receives both the sorted weights and their symbols. It adds runtime ascending/descending order, optional zero-weight-last placement, early termination and a non-zero entry count.

## Interface
- N, 10, number of entries (N ≥ 2)
- W, 13, bits per frequency
- TW, $clog2(N), tag width (derived localparam, not overridable)
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- START  in  1  one-cycle request; sampled only in IDLE
- DESCEND  in  1  0 = ascending, 1 = descending; captured with START
- ZERO_LAST  in  1  1 = zero-frequency entries sort after all non-zero entries regardless of order; captured with START
- FREQ_IN  in  N*W  entry i at bits [i*W +: W]
- BUSY  out  1  high from the cycle after START through the DONE cycle
- DONE  out  1  one-cycle pulse, results valid
- FREQ_OUT  out  N*W  sorted frequencies, position i at [i*W +: W]
- TAG_OUT  out  N*TW  original index of the entry at position i
- NZ_COUNT  out  TW+1  number of non-zero entries in the captured input

## Operation
- States: IDLE, SORT, DONE.
- IDLE: on START=1, capture FREQ_IN into the array, set tag[i]=i, latch DESCEND/ZERO_LAST, compute NZ_COUNT, clear phase counter and no-swap counter, go to SORT. START=0 leaves the state and outputs unchanged.
- SORT: one phase per cycle. Even phases (0,2,…) compare pairs (0,1),(2,3),…; odd phases compare pairs (1,2),(3,4),…. Phase parity is given by phase counter bit 0. All pairs are evaluated in parallel from current register values.
- Comparison key: k = {ZERO_LAST && f==0, f} (W+1 bits). Ascending: swap iff key(left) > key(right). Descending with ZERO_LAST=0: swap iff f(left) < f(right). Descending with ZERO_LAST=1: zeros are placed last, then non-zero entries sort descending. Tags move with their frequencies.
- Equal keys never swap, so the sort is stable and equal frequencies keep ascending tag order.
- Exit from SORT to DONE after the phase in which either the phase counter reaches N-1 (N phases completed) or two consecutive phases contained no swap.
- DONE: DONE=1 for one cycle, then IDLE. FREQ_OUT/TAG_OUT/NZ_COUNT hold until the next accepted START.
- START during SORT or DONE is ignored and not queued.
- FREQ_OUT/TAG_OUT drive the working array directly. During SORT they show intermediate values; they are valid only from DONE onward.
- Reset, including mid-sort: state IDLE, BUSY=0, DONE=0, FREQ_OUT=0, TAG_OUT=0, NZ_COUNT=0. A sort in progress is abandoned.

## Timing
- START is sampled at edge 0. Phases execute at edges 1..P. DONE is high during the cycle after edge P+1, so DONE is visible P+1 cycles after START.
- P ranges from 2 (input already in order) to N (worst case). For N=10 the latency is 3..11 cycles.
- BUSY is combinational from state (SORT or DONE). DONE and BUSY fall together when returning to IDLE.
- A new START is accepted in the first IDLE cycle after DONE, with no dead cycle beyond DONE.

## Test plan
- Reset: assert RST for 2 cycles mid-sort → next cycle BUSY=0, DONE=0, all outputs 0. A START 1 cycle after reset release sorts correctly.
- Already ascending, N=10, FREQ_IN={1,2,…,10}, DESCEND=0 → DONE 3 cycles after START, FREQ_OUT unchanged, TAG_OUT=0..9, NZ_COUNT=10.
- Reverse input {10,9,…,1}, DESCEND=0 → DONE at cycle 11, FREQ_OUT=1..10, TAG_OUT=9..0. Then DESCEND=1 on the same input → DONE at cycle 3.
- Ties and stability: FREQ_IN={5,3,5,3,0,0,7,3,5,1} ascending, ZERO_LAST=0 → FREQ_OUT={0,0,1,3,3,3,5,5,5,7}, TAG_OUT={4,5,9,1,3,7,0,2,8,6}, NZ_COUNT=8.
- Zero-last: same input with ZERO_LAST=1, ascending → FREQ_OUT={1,3,3,3,5,5,5,7,0,0}, zero tags {4,5} last. With DESCEND=1 → {7,5,5,5,3,3,3,1,0,0}.
- Handshake: pulse START again during SORT with different data → ignored, results match the first input, exactly one DONE pulse. A back-to-back START in the first IDLE cycle is accepted.

Source files
------------

// File: rtl/freq_sort_n.sv
// rtl/freq_sort_n.sv - sequential odd-even transposition frequency sorter with symbol tags
module freq_sort_n #(
    parameter int N = 10,
    parameter int W = 13
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic                   DESCEND,
    input  logic                   ZERO_LAST,
    input  logic [N*W-1:0]         FREQ_IN,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [N*W-1:0]         FREQ_OUT,
    output logic [N*$clog2(N)-1:0] TAG_OUT,
    output logic [$clog2(N):0]     NZ_COUNT
);
    localparam int TW = $clog2(N);
    // Phase count at which N phases have completed and the array is guaranteed sorted
    localparam logic [TW:0] PHASES_ALL = (TW+1)'(N);

    typedef enum logic [1:0] {ST_IDLE, ST_SORT, ST_DONE} state_t;

    state_t         state_q;
    logic           done_q;
    logic           desc_q;
    logic           zl_q;
    logic [TW:0]    phase_q;
    logic [1:0]     calm_q;      // consecutive phases without any swap
    logic [TW:0]    nz_q;
    logic [W-1:0]   freq_q [N];
    logic [TW-1:0]  tag_q  [N];
    logic [W-1:0]   freq_d [N];
    logic [TW-1:0]  tag_d  [N];
    logic           any_swap;
    logic [TW:0]    nz_d;

    // Swap decision for one adjacent pair; equal keys never swap so the sort stays stable
    function automatic logic need_swap(input logic [W-1:0] l, input logic [W-1:0] r,
                                       input logic desc, input logic zl);
        logic lz;
        logic rz;
        lz = zl && (l == '0);
        rz = zl && (r == '0);
        if (!desc) begin
            return {lz, l} > {rz, r};
        end
        // In descending order a zero flagged for last placement must still move right
        if (lz != rz) begin
            return lz;
        end
        return l < r;
    endfunction

    // One compare-swap phase over all pairs of the current parity, evaluated in parallel
    always_comb begin
        any_swap = 1'b0;
        for (int i = 0; i < N; i++) begin
            freq_d[i] = freq_q[i];
            tag_d[i]  = tag_q[i];
        end
        for (int i = 0; i + 1 < N; i++) begin
            if (((i % 2) == 1) == phase_q[0]) begin
                if (need_swap(freq_q[i], freq_q[i+1], desc_q, zl_q)) begin
                    freq_d[i]   = freq_q[i+1];
                    freq_d[i+1] = freq_q[i];
                    tag_d[i]    = tag_q[i+1];
                    tag_d[i+1]  = tag_q[i];
                    any_swap    = 1'b1;
                end
            end
        end
    end

    // Count of non-zero entries in the incoming frequency vector
    always_comb begin
        nz_d = '0;
        for (int i = 0; i < N; i++) begin
            nz_d = nz_d + (TW+1)'(FREQ_IN[i*W +: W] != '0);
        end
    end

    // Control FSM and working array
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            desc_q  <= 1'b0;
            zl_q    <= 1'b0;
            phase_q <= '0;
            calm_q  <= '0;
            nz_q    <= '0;
            for (int i = 0; i < N; i++) begin
                freq_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        for (int i = 0; i < N; i++) begin
                            freq_q[i] <= FREQ_IN[i*W +: W];
                            tag_q[i]  <= TW'(i);
                        end
                        desc_q  <= DESCEND;
                        zl_q    <= ZERO_LAST;
                        nz_q    <= nz_d;
                        phase_q <= '0;
                        calm_q  <= '0;
                        state_q <= ST_SORT;
                    end
                end
                ST_SORT: begin
                    if (phase_q == PHASES_ALL || calm_q == 2'd2) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        for (int i = 0; i < N; i++) begin
                            freq_q[i] <= freq_d[i];
                            tag_q[i]  <= tag_d[i];
                        end
                        phase_q <= phase_q + 1'b1;
                        calm_q  <= any_swap ? 2'd0 : calm_q + 2'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY     = (state_q != ST_IDLE);
    assign DONE     = done_q;
    assign NZ_COUNT = nz_q;

    for (genvar g = 0; g < N; g++) begin : g_out
        assign FREQ_OUT[g*W +: W]  = freq_q[g];
        assign TAG_OUT[g*TW +: TW] = tag_q[g];
    end

endmodule

// File: tb/tb_freq_sort_n.sv
// tb/tb_freq_sort_n.sv - directed self-checking bench for freq_sort_n
module tb_freq_sort_n;
    localparam int N  = 10;
    localparam int W  = 13;
    localparam int TW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            descend;
    logic            zero_last;
    logic [N*W-1:0]  freq_in;
    logic            busy;
    logic            done;
    logic [N*W-1:0]  freq_out;
    logic [N*TW-1:0] tag_out;
    logic [TW:0]     nz_count;

    int errors = 0;
    int checks = 0;

    int asc_in  [N];
    int rev_in  [N];
    int id_tag  [N];
    int rev_tag [N];
    int tie_in  [N];
    int tie_f   [N];
    int tie_t   [N];
    int zl_f    [N];
    int zl_t    [N];
    int zd_f    [N];
    int zd_t    [N];

    freq_sort_n #(.N(N), .W(W)) dut (
        .CLK(clk), .RST(rst), .START(start), .DESCEND(descend), .ZERO_LAST(zero_last),
        .FREQ_IN(freq_in), .BUSY(busy), .DONE(done), .FREQ_OUT(freq_out),
        .TAG_OUT(tag_out), .NZ_COUNT(nz_count)
    );

    always #5 clk = ~clk;

    function automatic logic [N*W-1:0] pack_f(input int v [N]);
        logic [N*W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(v[i]);
        return r;
    endfunction

    function automatic logic [N*TW-1:0] pack_t(input int v [N]);
        logic [N*TW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*TW +: TW] = TW'(v[i]);
        return r;
    endfunction

    // Issue one START at the current falling edge and wait (bounded) for DONE
    task automatic do_sort(input int v [N], input logic desc, input logic zl, output int lat);
        freq_in   = pack_f(v);
        descend   = desc;
        zero_last = zl;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat;
        freq_in = pack_f(rev_in); descend = 1'b0; zero_last = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (freq_out !== '0) begin errors++; $display("FAIL reset_freq: got %h want 0", freq_out); end
        checks++; if (tag_out !== '0) begin errors++; $display("FAIL reset_tag: got %h want 0", tag_out); end
        checks++; if (nz_count !== '0) begin errors++; $display("FAIL reset_nz: got %0d want 0", nz_count); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_after: got %b want 0", busy); end
        do_sort(tie_in, 1'b0, 1'b0, lat);
        checks++; if (lat < 0) begin errors++; $display("FAIL reset_resort_timeout: got %0d want done", lat); end
        checks++; if (freq_out !== pack_f(tie_f)) begin errors++; $display("FAIL reset_resort_freq: got %h want %h", freq_out, pack_f(tie_f)); end
    endtask

    task automatic test_sorted();
        int lat;
        @(negedge clk);
        do_sort(asc_in, 1'b0, 1'b0, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL sorted_lat: got %0d want 3", lat); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sorted_busy_in_done: got %b want 1", busy); end
        checks++; if (freq_out !== pack_f(asc_in)) begin errors++; $display("FAIL sorted_freq: got %h want %h", freq_out, pack_f(asc_in)); end
        checks++; if (tag_out !== pack_t(id_tag)) begin errors++; $display("FAIL sorted_tag: got %h want %h", tag_out, pack_t(id_tag)); end
        checks++; if (nz_count !== 5'd10) begin errors++; $display("FAIL sorted_nz: got %0d want 10", nz_count); end
    endtask

    task automatic test_reverse();
        int lat;
        @(negedge clk);
        do_sort(rev_in, 1'b0, 1'b0, lat);
        checks++; if (lat !== 11) begin errors++; $display("FAIL reverse_lat: got %0d want 11", lat); end
        checks++; if (freq_out !== pack_f(asc_in)) begin errors++; $display("FAIL reverse_freq: got %h want %h", freq_out, pack_f(asc_in)); end
        checks++; if (tag_out !== pack_t(rev_tag)) begin errors++; $display("FAIL reverse_tag: got %h want %h", tag_out, pack_t(rev_tag)); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reverse_idle: got done=%b busy=%b want 0 0", done, busy); end
        do_sort(rev_in, 1'b1, 1'b0, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL reverse_desc_lat: got %0d want 3", lat); end
        checks++; if (freq_out !== pack_f(rev_in)) begin errors++; $display("FAIL reverse_desc_freq: got %h want %h", freq_out, pack_f(rev_in)); end
        checks++; if (tag_out !== pack_t(id_tag)) begin errors++; $display("FAIL reverse_desc_tag: got %h want %h", tag_out, pack_t(id_tag)); end
    endtask

    task automatic test_ties();
        int lat;
        @(negedge clk);
        do_sort(tie_in, 1'b0, 1'b0, lat);
        checks++; if (freq_out !== pack_f(tie_f)) begin errors++; $display("FAIL ties_freq: got %h want %h", freq_out, pack_f(tie_f)); end
        checks++; if (tag_out !== pack_t(tie_t)) begin errors++; $display("FAIL ties_tag: got %h want %h", tag_out, pack_t(tie_t)); end
        checks++; if (nz_count !== 5'd8) begin errors++; $display("FAIL ties_nz: got %0d want 8", nz_count); end
        freq_in = pack_f(asc_in);
        repeat (2) @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ties_done_pulse: got %b want 0", done); end
        checks++; if (freq_out !== pack_f(tie_f) || tag_out !== pack_t(tie_t)) begin errors++; $display("FAIL ties_hold: got %h want %h", freq_out, pack_f(tie_f)); end
    endtask

    task automatic test_zero_last();
        int lat;
        @(negedge clk);
        do_sort(tie_in, 1'b0, 1'b1, lat);
        checks++; if (freq_out !== pack_f(zl_f)) begin errors++; $display("FAIL zl_asc_freq: got %h want %h", freq_out, pack_f(zl_f)); end
        checks++; if (tag_out !== pack_t(zl_t)) begin errors++; $display("FAIL zl_asc_tag: got %h want %h", tag_out, pack_t(zl_t)); end
        @(negedge clk);
        do_sort(tie_in, 1'b1, 1'b1, lat);
        checks++; if (freq_out !== pack_f(zd_f)) begin errors++; $display("FAIL zl_desc_freq: got %h want %h", freq_out, pack_f(zd_f)); end
        checks++; if (tag_out !== pack_t(zd_t)) begin errors++; $display("FAIL zl_desc_tag: got %h want %h", tag_out, pack_t(zd_t)); end
    endtask

    task automatic test_handshake();
        int pulses;
        int lat;
        @(negedge clk);
        freq_in = pack_f(rev_in); descend = 1'b0; zero_last = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        freq_in = pack_f(tie_in); descend = 1'b1; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL hs_pulses: got %0d want 1", pulses); end
        checks++; if (freq_out !== pack_f(asc_in)) begin errors++; $display("FAIL hs_freq: got %h want %h", freq_out, pack_f(asc_in)); end
        checks++; if (tag_out !== pack_t(rev_tag)) begin errors++; $display("FAIL hs_tag: got %h want %h", tag_out, pack_t(rev_tag)); end
        checks++; if (nz_count !== 5'd10) begin errors++; $display("FAIL hs_nz: got %0d want 10", nz_count); end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        do_sort(tie_in, 1'b0, 1'b0, lat);
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got done=%b busy=%b want 0 0", done, busy); end
        do_sort(asc_in, 1'b0, 1'b0, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_lat: got %0d want 3", lat); end
        checks++; if (freq_out !== pack_f(asc_in)) begin errors++; $display("FAIL b2b_freq: got %h want %h", freq_out, pack_f(asc_in)); end
        checks++; if (nz_count !== 5'd10) begin errors++; $display("FAIL b2b_nz: got %0d want 10", nz_count); end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            asc_in[i]  = i + 1;
            rev_in[i]  = N - i;
            id_tag[i]  = i;
            rev_tag[i] = N - 1 - i;
        end
        tie_in = '{5, 3, 5, 3, 0, 0, 7, 3, 5, 1};
        tie_f  = '{0, 0, 1, 3, 3, 3, 5, 5, 5, 7};
        tie_t  = '{4, 5, 9, 1, 3, 7, 0, 2, 8, 6};
        zl_f   = '{1, 3, 3, 3, 5, 5, 5, 7, 0, 0};
        zl_t   = '{9, 1, 3, 7, 0, 2, 8, 6, 4, 5};
        zd_f   = '{7, 5, 5, 5, 3, 3, 3, 1, 0, 0};
        zd_t   = '{6, 0, 2, 8, 1, 3, 7, 9, 4, 5};

        rst = 1'b1; start = 1'b0; descend = 1'b0; zero_last = 1'b0; freq_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        test_reset();
        test_sorted();
        test_reverse();
        test_ties();
        test_zero_last();
        test_handshake();
        test_back_to_back();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
